// File: rtl/countdown_digit_display.sv
// countdown_digit_display: mm:ss BCD countdown with a shared glyph ROM scanned across four digit slots
module countdown_digit_display #(
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 96,
    parameter int GAP       = 16,
    parameter int CLK_HZ    = 65000000,
    parameter int START_MIN = 5,
    parameter int START_SEC = 0
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  pixel_index,
    output logic        pixel_on,
    output logic        running,
    output logic        expired
);
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam int PITCH = WIDTH + GAP;
    localparam logic [3:0][3:0] T0 = {4'(START_MIN / 10), 4'(START_MIN % 10), 4'(START_SEC / 10), 4'(START_SEC % 10)};
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    state_t state;
    logic [3:0][3:0] t, nt;
    logic [PW-1:0] presc;
    logic [15:0] h16, v16, x16, y16, addr_c;
    logic hit_c, v1, v2;
    assign h16 = 16'(hcount);
    assign v16 = 16'(vcount);
    assign x16 = 16'(x);
    assign y16 = 16'(y);
    // one-second decrement of the BCD time; t[3]=m1, t[2]=m0, t[1]=s1, t[0]=s0
    always_comb begin
        nt = t;
        nt[0] = t[0] == 4'd0 ? 4'd9 : t[0] - 4'd1;
        if (t[0] == 4'd0) begin
            nt[1] = t[1] == 4'd0 ? 4'd5 : t[1] - 4'd1;
            if (t[1] == 4'd0) begin
                nt[2] = t[2] == 4'd0 ? 4'd9 : t[2] - 4'd1;
                if (t[2] == 4'd0) nt[3] = t[3] - 4'd1;
            end
        end
    end
    // countdown sequencer; hold beats a coincident prescaler wrap
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state <= IDLE;
            t <= T0;
            presc <= '0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    t <= T0;
                    presc <= '0;
                    if (start) begin
                        state <= T0 == '0 ? DONE : RUN;
                        running <= T0 != '0;
                        expired <= T0 == '0;
                    end
                end
                RUN: begin
                    if (hold) begin
                        state <= HOLD;
                        running <= 1'b0;
                    end else if (presc == PW'(CLK_HZ - 1)) begin
                        presc <= '0;
                        t <= nt;
                        if (nt == '0) begin
                            state <= DONE;
                            running <= 1'b0;
                            expired <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        state <= RUN;
                        running <= 1'b1;
                    end
                end
                default: t <= '0;
            endcase
        end
    end
    // slot hit test and glyph address for the current scan position
    always_comb begin
        addr_c = '0;
        hit_c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (v16 >= y16 && v16 - y16 < 16'(HEIGHT) && h16 >= x16 + 16'(k * PITCH) && h16 - x16 - 16'(k * PITCH) < 16'(WIDTH)) begin
                hit_c = 1'b1;
                addr_c = 16'(t[2'(3 - k)]) * 16'(WIDTH * HEIGHT) + (h16 - x16 - 16'(k * PITCH)) + (v16 - y16) * 16'(WIDTH);
            end
        end
    end
    // address register, then slot-valid carried alongside the ROM read
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            pixel_on <= 1'b0;
            pixel_index <= '0;
        end else begin
            rom_addr <= addr_c;
            v1 <= hit_c;
            v2 <= v1;
            pixel_on <= v2;
            pixel_index <= v2 ? rom_data : '0;
        end
    end
endmodule

// File: tb/tb_countdown_digit_display.sv
// tb_countdown_digit_display: scoreboard bench with a seconds-based reference model
module tb_countdown_digit_display;
    localparam int CLK_HZ = 4;
    localparam int START_T = 12 * 60 + 34;
    localparam int X0 = 100;
    localparam int Y0 = 50;
    typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mst_t;
    typedef struct {int t; logic [15:0] a; logic on; logic [7:0] idx;} exp_t;
    logic pixel_clk = 1'b0;
    logic rst_n = 1'b0, start = 1'b0, hold = 1'b0;
    logic [10:0] x = 11'(X0), hcount = '0;
    logic [9:0] y = 10'(Y0), vcount = '0;
    logic [15:0] rom_addr, z_rom_addr;
    logic [7:0] rom_data = '0, pixel_index, z_pixel_index;
    logic [7:0] z_rom_data = 8'h3C;
    logic pixel_on, running, expired, z_pixel_on, z_running, z_expired;
    int cyc = 0, n_chk = 0, n_fail = 0;
    mst_t m_st;
    int m_t, m_p;
    exp_t aq[$], pq[$];
    exp_t e;

    countdown_digit_display #(.WIDTH(64), .HEIGHT(96), .GAP(16), .CLK_HZ(CLK_HZ), .START_MIN(12), .START_SEC(34)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .start(start), .hold(hold), .x(x), .y(y),
        .hcount(hcount), .vcount(vcount), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_index(pixel_index), .pixel_on(pixel_on), .running(running), .expired(expired));

    countdown_digit_display #(.WIDTH(64), .HEIGHT(96), .GAP(16), .CLK_HZ(2), .START_MIN(0), .START_SEC(0)) u_zero (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .start(start), .hold(hold), .x(x), .y(y),
        .hcount(hcount), .vcount(vcount), .rom_addr(z_rom_addr), .rom_data(z_rom_data),
        .pixel_index(z_pixel_index), .pixel_on(z_pixel_on), .running(z_running), .expired(z_expired));

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    always @(posedge pixel_clk) rom_data <= rom_fn(rom_addr);
    always @(posedge pixel_clk) cyc <= cyc + 1;

    // reference: remaining time kept as a plain count of seconds
    always @(posedge pixel_clk) begin
        if (!rst_n) begin
            m_st <= M_IDLE;
            m_t <= START_T;
            m_p <= 0;
        end else begin
            case (m_st)
                M_IDLE: if (start) m_st <= START_T == 0 ? M_DONE : M_RUN;
                M_RUN: begin
                    if (hold) m_st <= M_HOLD;
                    else if (m_p == CLK_HZ - 1) begin
                        m_p <= 0;
                        m_t <= m_t - 1;
                        if (m_t == 1) m_st <= M_DONE;
                    end else m_p <= m_p + 1;
                end
                M_HOLD: if (!hold) m_st <= M_RUN;
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void expect_px(input int h, input int v, output logic on, output logic [15:0] a);
        int mm = m_t / 60;
        int ss = m_t % 60;
        int dg[4] = '{mm / 10, mm % 10, ss / 10, ss % 10};
        on = 1'b0;
        a = '0;
        for (int k = 0; k < 4; k++) begin
            int l = X0 + k * 80;
            if (h >= l && h < l + 64 && v >= Y0 && v < Y0 + 96) begin
                on = 1'b1;
                a = 16'(dg[k] * 6144 + (h - l) + (v - Y0) * 64);
            end
        end
    endfunction

    task automatic step(input logic r, input logic s, input logic hd, input int h, input int v);
        logic on;
        logic [15:0] a;
        @(posedge pixel_clk);
        #1;
        rst_n = r;
        start = s;
        hold = hd;
        hcount = 11'(h);
        vcount = 10'(v);
        if (!r) begin
            aq.delete();
            pq.delete();
        end else begin
            expect_px(h, v, on, a);
            aq.push_back('{cyc + 1, a, on, 8'h00});
            pq.push_back('{cyc + 3, a, on, on ? rom_fn(a) : 8'h00});
        end
    endtask

    task automatic rstep(input logic r, input logic s, input logic hd, input int fixk);
        int k = fixk >= 0 ? fixk : cyc % 4;
        int h, v;
        if (fixk < 0 && $urandom_range(0, 7) == 0) begin
            h = X0 + k * 80 + 64 + int'($urandom_range(0, 15));
            v = Y0 + int'($urandom_range(0, 120));
        end else begin
            h = X0 + k * 80 + int'($urandom_range(0, 63));
            v = Y0 + int'($urandom_range(0, 95));
        end
        step(r, s, hd, h, v);
    endtask

    task automatic reset_chk();
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_pixel_index", 32'(pixel_index), 32'h0);
        chk("rst_pixel_on", 32'(pixel_on), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_expired", 32'(expired), 32'h0);
        chk("rst_zero_expired", 32'(z_expired), 32'h0);
        chk("rst_zero_outputs", {z_rom_addr, z_pixel_index, 7'h0, z_pixel_on | z_running}, 32'h0);
    endtask

    // monitor: state flags every cycle, address and pixel outputs as they come due
    always @(negedge pixel_clk) begin
        chk("running", 32'(running), 32'(m_st == M_RUN));
        chk("expired", 32'(expired), 32'(m_st == M_DONE));
        while (aq.size() > 0 && aq[0].t <= cyc) begin
            e = aq.pop_front();
            chk("rom_addr", 32'(rom_addr), 32'(e.a));
        end
        while (pq.size() > 0 && pq[0].t <= cyc) begin
            e = pq.pop_front();
            chk("pixel_on", 32'(pixel_on), 32'(e.on));
            chk("pixel_index", 32'(pixel_index), 32'(e.idx));
        end
    end

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge pixel_clk);
        reset_chk();
        step(1, 0, 0, X0 + 80 + 3, Y0 + 2);
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk("addr_12419", 32'(rom_addr), 32'd12419);
        step(1, 0, 0, X0 + 64, Y0 + 2);
        step(1, 0, 0, X0 + 20, Y0 + 96);
        step(1, 0, 0, X0, Y0 + 95);
        step(1, 0, 0, X0 + 240 + 63, Y0);
        step(1, 0, 0, X0 + 240 + 64, Y0);
        repeat (8) rstep(1, 0, 0, -1);
        rstep(1, 1, 0, -1);
        rstep(1, 0, 0, -1);
        @(negedge pixel_clk);
        chk("start_running", 32'(running), 32'h1);
        chk("zero_start_expired", {z_expired, z_running}, 32'h2);
        repeat (40) rstep(1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), -1);
        rstep(0, 0, 0, -1);
        rstep(1, 0, 0, -1);
        @(negedge pixel_clk);
        reset_chk();
        repeat (6) rstep(1, 0, 0, -1);
        rstep(1, 1, 0, -1);
        rstep(1, 0, 0, -1);
        @(negedge pixel_clk);
        chk("rearm_zero_expired", 32'(z_expired), 32'h1);
        for (int i = 0; i < 20 && !(m_st == M_RUN && m_p == CLK_HZ - 1); i++) rstep(1, 0, 0, 3);
        if (!(m_st == M_RUN && m_p == CLK_HZ - 1)) begin
            n_chk++;
            n_fail++;
            $display("FAIL hold_sync: prescaler wrap not reached within budget");
        end
        repeat (5) rstep(1, 0, 1, 3);
        repeat (10) rstep(1, 0, 0, 3);
        for (int i = 0; i < 6000 && m_st != M_DONE; i++)
            rstep(1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0), -1);
        if (m_st != M_DONE) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: countdown did not reach 00:00 within budget");
        end
        repeat (12) rstep(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        repeat (5) @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk("scoreboard_drained", 32'(aq.size() + pq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_digit_display.md
# countdown_digit_display

Countdown timer controller for the bomb display. It holds an mm:ss countdown in BCD, sequences it with a one-second prescaler, and shares a single glyph ROM between the four on-screen digit positions. It does this by computing, per pixel, which digit slot is being scanned and which glyph address to fetch. Output is a palette index plus a valid flag, aligned for the downstream colour tables and the pixel mux.

## Interface
- WIDTH, 64, glyph width in pixels
- HEIGHT, 96, glyph height in pixels
- GAP, 16, horizontal pixels between adjacent digit slots
- CLK_HZ, 65000000, pixel_clk cycles per countdown second
- START_MIN, 5, reset/idle minutes value (0-99)
- START_SEC, 0, reset/idle seconds value (0-59)

- pixel_clk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  level; begins countdown from IDLE
- hold  in  1  level; freezes countdown while high
- x  in  11  left edge of slot 0
- y  in  10  top edge of all slots
- hcount  in  11  current scan column
- vcount  in  10  current scan row
- rom_addr  out  16  glyph ROM address, registered
- rom_data  in  8  glyph ROM data, valid one cycle after rom_addr
- pixel_index  out  8  palette index for current pixel
- pixel_on  out  1  pixel_index is inside a digit slot
- running  out  1  state is RUN
- expired  out  1  state is DONE

## Operation
- Digits are BCD registers m1, m0, s1, s0. Slot k (k = 0..3, in that order) spans columns x + k·(WIDTH+GAP) to that value + WIDTH−1, and rows y to y+HEIGHT−1.
- State machine:
  - IDLE: time = START_MIN:START_SEC, prescaler = 0. start=1 → RUN (or → DONE if the start value is 00:00).
  - RUN: prescaler counts 0..CLK_HZ−1. On wrap, emit an internal tick. hold=1 → HOLD, with prescaler and time frozen in that same cycle.
  - HOLD: nothing changes. hold=0 → RUN, prescaler resumes from its frozen value.
  - DONE: time = 00:00, expired=1. Only rst_n exits.
- Tick decrement:
  - s0−1; if s0 = 0, then s0=9 and borrow into s1.
  - If s1 = 0 on borrow, then s1=5 and borrow into m0; m0 wraps 0→9 with borrow into m1.
  - If the result is 00:00, go to DONE in the same edge.
- Simultaneous tick and hold: hold wins, and the tick is not taken.
- start is ignored outside IDLE.
- Address generation, per cycle:
  - Find slot k with hcount, vcount inside it.
  - Select digit d from k.
  - rom_addr = d·WIDTH·HEIGHT + (hcount − slot_left) + (vcount − y)·WIDTH.
  - Compute all arithmetic at 16 bits unsigned.
  - Outside all slots, rom_addr = 0 and the slot-valid flag = 0.
- The slot-valid flag is pipelined alongside the ROM access. pixel_index = rom_data when valid, else 0.
- Digit values are sampled at the address stage, so a mid-frame tick changes glyphs from the next fetched pixel on.
- Reset values: state IDLE, time START_MIN:START_SEC, prescaler 0, rom_addr 0, pixel_index 0, pixel_on 0, running 0, expired 0. Pipeline valid bits are also cleared.

## Timing
- hcount/vcount sampled at edge n → rom_addr at edge n+1 → rom_data valid after edge n+2 → pixel_index/pixel_on at edge n+3. Fixed 3-cycle latency in all states.
- Countdown of one second takes exactly CLK_HZ RUN cycles. HOLD cycles do not count.
- running and expired are registered, updating on the same edge as the state change.
- Reset asserted mid-countdown or mid-line: all outputs take reset values at the next edge, and the first valid pixel follows 3 cycles after release.

## Test plan
- Reset, CLK_HZ=4, START 00:03: pulse start. Required: running=1 next edge, 00:02 after 4 cycles, expired=1 after exactly 12 RUN cycles, rom of "0" glyphs displayed.
- START 10:00, CLK_HZ=2, run one tick. Required: 09:59 (borrow through s0, s1, m0). Then from 01:00, one tick → 00:59.
- Assert hold in the same cycle as the prescaler wrap, hold 5 cycles. Required: time unchanged; tick lands exactly 1 cycle after hold drops.
- x=100, y=50, time 12:34, scan hcount=100+80+3, vcount=52. Required: rom_addr = 2·6144 + 3 + 128 = 12419 one edge later. Provide ROM data 0xA5 → pixel_index=0xA5, pixel_on=1 at edge n+3.
- Scan a gap column (hcount = x+64) and a row y+96. Required: pixel_on=0, pixel_index=0.
- START 00:00, start=1. Required: DONE next edge, expired=1. Then assert rst_n=0 mid-run for one cycle. Required: IDLE, outputs at reset values, start re-arms.
